// File: rtl/rtc_pkg.sv
// Shared register map, status/fire-control bit positions and fire FSM states for rtc_multi_capture.
// Register index sits in address[15:8]. The channel index sits in address[7:0].
package rtc_pkg;

   localparam logic [7:0] REG_TIME       = 8'h00;
   localparam logic [7:0] REG_CAPTURE    = 8'h01;
   localparam logic [7:0] REG_STATUS     = 8'h02;
   localparam logic [7:0] REG_FIRE_TIME  = 8'h03;
   localparam logic [7:0] REG_FIRE_CTRL  = 8'h04;
   localparam logic [7:0] REG_FIRE_STAMP = 8'h05;
   localparam logic [7:0] REG_EDGE_SEL   = 8'h06;

   // STATUS read bits, then STATUS write command bits
   localparam int STAT_ARMED     = 0;
   localparam int STAT_VALID     = 1;
   localparam int STAT_OVERRUN   = 2;
   localparam int STAT_WR_ARM    = 0;
   localparam int STAT_WR_DISARM = 1;

   // FIRE_CTRL write command bits, then FIRE_CTRL read bits
   localparam int FC_SCHEDULE = 0;
   localparam int FC_FIRE     = 1;
   localparam int FC_CANCEL   = 2;
   localparam int FC_PENDING  = 0;
   localparam int FC_ACTIVE   = 1;

   typedef enum logic [1:0] {
      FIRE_IDLE    = 2'd0,
      FIRE_PENDING = 2'd1,
      FIRE_ACTIVE  = 2'd2
   } fire_state_e;

   localparam logic [31:0] RD_INVALID = 32'hDEADBEEF;

endpackage

// File: rtl/rtc_capture_channel.sv
// One timestamp-capture channel: input synchroniser, edge detect, armed/valid/overrun flags and capture register.
// Input edge to valid takes SYNC_STAGES+1 clocks. There is no backpressure. RTC_EDGE_SELECT_EN adds a per-channel edge select.
module rtc_capture_channel
   import rtc_pkg::*;
#(
   parameter int CNT_W       = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             event_i,
   input  logic [CNT_W-1:0] time_i,
   input  logic             status_wr_i,
   input  logic [1:0]       status_wdat_i,
`ifdef RTC_EDGE_SELECT_EN
   input  logic [1:0]       edge_sel_i,
`endif
   output logic             armed_o,
   output logic             valid_o,
   output logic             overrun_o,
   output logic [CNT_W-1:0] capture_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   rise, detect;
   logic                   armed_q, armed_d, valid_q, valid_d, overrun_q, overrun_d;
   logic [CNT_W-1:0]       cap_q, cap_d;

   assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

`ifdef RTC_EDGE_SELECT_EN
   logic fall;
   assign fall = ~sync_q[SYNC_STAGES-1] & prev_q;

   always_comb begin
      case (edge_sel_i)
         2'b01:   detect = fall;
         2'b10:   detect = rise | fall;
         default: detect = rise;
      endcase
   end
`else
   assign detect = rise;
`endif

   // A STATUS write takes the cycle outright, so a coincident edge is dropped
   always_comb begin
      armed_d   = armed_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;
      cap_d     = cap_q;
      if (status_wr_i) begin
         if (status_wdat_i[STAT_WR_DISARM]) begin
            armed_d = 1'b0;
         end else if (status_wdat_i[STAT_WR_ARM]) begin
            armed_d   = 1'b1;
            valid_d   = 1'b0;
            overrun_d = 1'b0;
         end
      end else if (detect) begin
         if (armed_q) begin
            cap_d   = time_i;
            valid_d = 1'b1;
            armed_d = 1'b0;
         end else if (valid_q) begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q    <= '0;
         prev_q    <= 1'b0;
         armed_q   <= 1'b0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
         cap_q     <= '0;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], event_i};
         prev_q    <= sync_q[SYNC_STAGES-1];
         armed_q   <= armed_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
         cap_q     <= cap_d;
      end
   end

   assign armed_o   = armed_q;
   assign valid_o   = valid_q;
   assign overrun_o = overrun_q;
   assign capture_o = cap_q;

endmodule

// File: rtl/rtc_multi_capture.sv
// RTC with a prescaled timebase, NUM_CH timestamp-capture channels and a scheduled/immediate fire pulse, exposed as an Avalon-MM slave.
// Reads take 1 wait state with registered readdata. Writes take 0 wait states. RTC_EDGE_SELECT_EN adds the EDGE_SEL register.
module rtc_multi_capture
   import rtc_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int CNT_W       = 32,
   parameter int PRESCALE    = 5,
   parameter int SYNC_STAGES = 2,
   parameter int PULSE_TICKS = 10
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [NUM_CH-1:0] event_in,
   input  logic [15:0]       avalon_slave_address,
   input  logic              avalon_slave_write,
   input  logic [31:0]       avalon_slave_writedata,
   input  logic              avalon_slave_read,
   output logic [31:0]       avalon_slave_readdata,
   output logic              avalon_slave_waitrequest,
   output logic              fire_out,
   output logic              capture_irq
);

   localparam int PW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int PCW = (PULSE_TICKS > 1) ? $clog2(PULSE_TICKS) : 1;

   logic [7:0]       reg_sel, ch_sel;
   logic             wr_time, wr_fctrl, sched_req, fire_req, cancel_req;
   logic [PW-1:0]    presc_q, presc_d;
   logic [CNT_W-1:0] time_q, time_d, time_inc;
   logic             tick, match, entering;
   fire_state_e      state_q, state_d;
   logic [PCW-1:0]   pcnt_q, pcnt_d;
   logic             fire_q;
   logic [CNT_W-1:0] fire_time_q, stamp_q;
   logic             rd_done_q, rd_take;
   logic [31:0]      rdata_q, rd_mux, stat_sel;
   logic             ch_hit;
   logic [CNT_W-1:0] cap_sel;
   logic [NUM_CH-1:0] armed, valid, overrun;
   logic [CNT_W-1:0] cap [NUM_CH];

   assign reg_sel    = avalon_slave_address[15:8];
   assign ch_sel     = avalon_slave_address[7:0];
   assign wr_time    = avalon_slave_write && (reg_sel == REG_TIME);
   assign wr_fctrl   = avalon_slave_write && (reg_sel == REG_FIRE_CTRL);
   assign cancel_req = wr_fctrl & avalon_slave_writedata[FC_CANCEL];
   assign sched_req  = wr_fctrl & avalon_slave_writedata[FC_SCHEDULE] & ~cancel_req;
   assign fire_req   = wr_fctrl & avalon_slave_writedata[FC_FIRE] & ~cancel_req;

   assign tick     = (presc_q == PW'(PRESCALE - 1));
   assign time_inc = time_q + CNT_W'(1);

   always_comb begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      time_d  = tick ? time_inc : time_q;
      if (wr_time) begin
         presc_d = '0;
         time_d  = avalon_slave_writedata[CNT_W-1:0];
      end
   end

   // Matching on time_inc fires on the tick that brings time_cnt to FIRE_TIME
   assign match = tick & ~wr_time & (time_inc == fire_time_q);

   always_comb begin
      state_d = state_q;
      pcnt_d  = pcnt_q;
      case (state_q)
         FIRE_IDLE: begin
            if (fire_req)       state_d = FIRE_ACTIVE;
            else if (sched_req) state_d = FIRE_PENDING;
         end
         FIRE_PENDING: begin
            if (cancel_req)             state_d = FIRE_IDLE;
            else if (fire_req || match) state_d = FIRE_ACTIVE;
         end
         FIRE_ACTIVE: begin
            if (cancel_req) begin
               state_d = FIRE_IDLE;
            end else if (tick) begin
               if (pcnt_q == PCW'(PULSE_TICKS - 1)) state_d = FIRE_IDLE;
               else                                 pcnt_d  = pcnt_q + PCW'(1);
            end
         end
         default: state_d = FIRE_IDLE;
      endcase
      entering = (state_d == FIRE_ACTIVE) && (state_q != FIRE_ACTIVE);
      if (entering) pcnt_d = '0;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         presc_q     <= '0;
         time_q      <= '0;
         state_q     <= FIRE_IDLE;
         pcnt_q      <= '0;
         fire_q      <= 1'b0;
         fire_time_q <= '0;
         stamp_q     <= '0;
      end else begin
         presc_q <= presc_d;
         time_q  <= time_d;
         state_q <= state_d;
         pcnt_q  <= pcnt_d;
         fire_q  <= (state_d == FIRE_ACTIVE);
         if (entering) stamp_q <= time_d;
         if (avalon_slave_write && (reg_sel == REG_FIRE_TIME))
            fire_time_q <= avalon_slave_writedata[CNT_W-1:0];
      end
   end

`ifdef RTC_EDGE_SELECT_EN
   logic [1:0] esel_q [NUM_CH];
   logic [1:0] esel_sel;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_CH; i++) esel_q[i] <= 2'b00;
      end else if (avalon_slave_write && (reg_sel == REG_EDGE_SEL)) begin
         for (int i = 0; i < NUM_CH; i++)
            if (ch_sel == 8'(i)) esel_q[i] <= avalon_slave_writedata[1:0];
      end
   end
`endif

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic st_wr;
      assign st_wr = avalon_slave_write && (reg_sel == REG_STATUS) && (ch_sel == 8'(g));

      rtc_capture_channel #(
         .CNT_W       (CNT_W),
         .SYNC_STAGES (SYNC_STAGES)
      ) u_ch (
         .clk_i         (clock),
         .rst_ni        (reset_n),
         .event_i       (event_in[g]),
         .time_i        (time_q),
         .status_wr_i   (st_wr),
         .status_wdat_i (avalon_slave_writedata[1:0]),
`ifdef RTC_EDGE_SELECT_EN
         .edge_sel_i    (esel_q[g]),
`endif
         .armed_o       (armed[g]),
         .valid_o       (valid[g]),
         .overrun_o     (overrun[g]),
         .capture_o     (cap[g])
      );
   end

   always_comb begin
      ch_hit   = 1'b0;
      cap_sel  = '0;
      stat_sel = '0;
`ifdef RTC_EDGE_SELECT_EN
      esel_sel = 2'b00;
`endif
      for (int i = 0; i < NUM_CH; i++) begin
         if (ch_sel == 8'(i)) begin
            ch_hit                 = 1'b1;
            cap_sel                = cap[i];
            stat_sel[STAT_ARMED]   = armed[i];
            stat_sel[STAT_VALID]   = valid[i];
            stat_sel[STAT_OVERRUN] = overrun[i];
`ifdef RTC_EDGE_SELECT_EN
            esel_sel               = esel_q[i];
`endif
         end
      end

      rd_mux = RD_INVALID;
      case (reg_sel)
         REG_TIME:       rd_mux = 32'(time_q);
         REG_CAPTURE:    if (ch_hit) rd_mux = 32'(cap_sel);
         REG_STATUS:     if (ch_hit) rd_mux = stat_sel;
         REG_FIRE_TIME:  rd_mux = 32'(fire_time_q);
         REG_FIRE_CTRL: begin
            rd_mux            = '0;
            rd_mux[FC_PENDING] = (state_q == FIRE_PENDING);
            rd_mux[FC_ACTIVE]  = (state_q == FIRE_ACTIVE);
         end
         REG_FIRE_STAMP: rd_mux = 32'(stamp_q);
`ifdef RTC_EDGE_SELECT_EN
         REG_EDGE_SEL:   if (ch_hit) rd_mux = 32'(esel_sel);
`endif
         default:        rd_mux = RD_INVALID;
      endcase
   end

   // First read cycle stalls and registers the data; the second completes with waitrequest low
   assign rd_take = avalon_slave_read & ~rd_done_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_done_q <= 1'b0;
         rdata_q   <= '0;
      end else begin
         rd_done_q <= rd_take;
         if (rd_take) rdata_q <= rd_mux;
      end
   end

   assign avalon_slave_readdata    = rdata_q;
   assign avalon_slave_waitrequest = rd_take;
   assign fire_out                 = fire_q;
   assign capture_irq              = |valid;

endmodule

// File: tb/tb_rtc_multi_capture.sv
// Directed self-checking bench for rtc_multi_capture (default parameters, 10 ns clock).
// Inputs change on the falling edge, and outputs are sampled on the falling edge or between edges.
module tb_rtc_multi_capture;

   localparam logic [7:0] R_TIME = 8'h00, R_CAP = 8'h01, R_STAT = 8'h02, R_FTIME = 8'h03;
   localparam logic [7:0] R_FCTRL = 8'h04, R_FSTAMP = 8'h05, R_ESEL = 8'h06;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [3:0]  event_in;
   logic [15:0] address;
   logic        write, read;
   logic [31:0] writedata, readdata;
   logic        waitrequest, fire_out, capture_irq;

   int n_cmp  = 0;
   int n_fail = 0;

   rtc_multi_capture dut (
      .clock                    (clock),
      .reset_n                  (reset_n),
      .event_in                 (event_in),
      .avalon_slave_address     (address),
      .avalon_slave_write       (write),
      .avalon_slave_writedata   (writedata),
      .avalon_slave_read        (read),
      .avalon_slave_readdata    (readdata),
      .avalon_slave_waitrequest (waitrequest),
      .fire_out                 (fire_out),
      .capture_irq              (capture_irq)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic bus_write(input logic [7:0] rg, input logic [7:0] ch, input logic [31:0] d);
      @(negedge clock);
      address   = {rg, ch};
      writedata = d;
      write     = 1'b1;
      @(negedge clock);
      write = 1'b0;
   endtask

   task automatic bus_read(input logic [7:0] rg, input logic [7:0] ch,
                           output logic [31:0] d, output int waits);
      @(negedge clock);
      address = {rg, ch};
      read    = 1'b1;
      waits   = 0;
      #1;
      while (waitrequest && waits < 8) begin
         waits++;
         @(negedge clock);
      end
      d = readdata;
      @(posedge clock);
      #1;
      read = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [7:0] rg, input logic [7:0] ch,
                         input logic [31:0] exp);
      logic [31:0] d;
      int          w;
      bus_read(rg, ch, d, w);
      check(tag, d, exp);
   endtask

   task automatic pulse_event(input int ch);
      event_in[ch] = 1'b1;
      repeat (4) @(negedge clock);
      event_in[ch] = 1'b0;
      repeat (4) @(negedge clock);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      int          w, cnt, hi;
      logic        seen;

      reset_n = 1'b0; event_in = '0; address = '0; write = 1'b0; read = 1'b0; writedata = '0;
      repeat (2) @(negedge clock);
      check("rst_fire_out", {31'd0, fire_out}, 32'd0);
      check("rst_irq", {31'd0, capture_irq}, 32'd0);
      check("rst_readdata", readdata, 32'd0);
      check("rst_waitreq", {31'd0, waitrequest}, 32'd0);
      reset_n = 1'b1;
      rd_chk("rst_status0", R_STAT, 8'd0, 32'd0);
      rd_chk("rst_capture1", R_CAP, 8'd1, 32'd0);
      rd_chk("rst_fire_ctrl", R_FCTRL, 8'd0, 32'd0);
      rd_chk("rst_fire_stamp", R_FSTAMP, 8'd0, 32'd0);

      // Timebase load and wrap
      bus_write(R_TIME, 8'd0, 32'hFFFF_FFFE);
      rd_chk("time_load", R_TIME, 8'd0, 32'hFFFF_FFFE);
      bus_write(R_TIME, 8'd0, 32'hFFFF_FFFE);
      repeat (15) @(negedge clock);
      rd_chk("time_wrap", R_TIME, 8'd0, 32'h0000_0001);

      // Zero-wait-state write
      @(negedge clock);
      address = {R_FTIME, 8'd0}; writedata = 32'h0000_1234; write = 1'b1;
      #1 check("wr_no_wait", {31'd0, waitrequest}, 32'd0);
      @(negedge clock);
      write = 1'b0;
      rd_chk("fire_time_rb", R_FTIME, 8'd0, 32'h0000_1234);

      // Single-channel capture and latency
      bus_write(R_STAT, 8'd2, 32'd1);
      rd_chk("arm_ch2", R_STAT, 8'd2, 32'd1);
      bus_write(R_TIME, 8'd0, 32'h0000_0100);
      event_in[2] = 1'b1;
      repeat (2) @(negedge clock);
      check("lat_2clk_irq", {31'd0, capture_irq}, 32'd0);
      @(negedge clock);
      check("lat_3clk_irq", {31'd0, capture_irq}, 32'd1);
      event_in[2] = 1'b0;
      rd_chk("cap2", R_CAP, 8'd2, 32'h0000_0100);
      rd_chk("status2_valid", R_STAT, 8'd2, 32'd2);

      // Overrun on ch0
      bus_write(R_STAT, 8'd0, 32'd1);
      bus_write(R_TIME, 8'd0, 32'h0000_0055);
      pulse_event(0);
      rd_chk("cap0_first", R_CAP, 8'd0, 32'h0000_0055);
      rd_chk("status0_valid", R_STAT, 8'd0, 32'd2);
      pulse_event(0);
      rd_chk("status0_overrun", R_STAT, 8'd0, 32'd6);
      rd_chk("cap0_kept", R_CAP, 8'd0, 32'h0000_0055);
      bus_write(R_STAT, 8'd2, 32'd1);
      bus_write(R_STAT, 8'd0, 32'd1);
      rd_chk("status0_rearm", R_STAT, 8'd0, 32'd1);
      check("irq_cleared", {31'd0, capture_irq}, 32'd0);
      bus_write(R_STAT, 8'd2, 32'd3);
      rd_chk("disarm_wins", R_STAT, 8'd2, 32'd0);
      pulse_event(2);
      rd_chk("unarmed_ignored", R_STAT, 8'd2, 32'd0);
      check("unarmed_irq", {31'd0, capture_irq}, 32'd0);

      // Arm write coincident with the detect cycle
      bus_write(R_STAT, 8'd1, 32'd1);
      @(negedge clock);
      event_in[1] = 1'b1;
      @(negedge clock);
      bus_write(R_STAT, 8'd1, 32'd1);
      rd_chk("arm_vs_edge", R_STAT, 8'd1, 32'd1);
      event_in[1] = 1'b0;

      // Scheduled fire: 16 ticks of 5 clocks after the TIME load, minus 4 clocks of setup writes
      bus_write(R_TIME, 8'd0, 32'h0000_01F0);
      bus_write(R_FTIME, 8'd0, 32'h0000_0200);
      bus_write(R_FCTRL, 8'd0, 32'd1);
      cnt = 0;
      while (!fire_out && cnt < 200) begin
         @(negedge clock);
         cnt++;
      end
      check("fire_delay", cnt, 32'd76);
      hi = 0;
      while (fire_out && hi < 200) begin
         @(negedge clock);
         hi++;
      end
      check("fire_width", hi, 32'd50);
      rd_chk("fire_stamp", R_FSTAMP, 8'd0, 32'h0000_0200);
      rd_chk("fire_ctrl_done", R_FCTRL, 8'd0, 32'd0);

      // Cancel before match
      bus_write(R_TIME, 8'd0, 32'h0000_0300);
      bus_write(R_FTIME, 8'd0, 32'h0000_0305);
      bus_write(R_FCTRL, 8'd0, 32'd1);
      rd_chk("fire_pending", R_FCTRL, 8'd0, 32'd1);
      bus_write(R_FCTRL, 8'd0, 32'd4);
      rd_chk("cancelled", R_FCTRL, 8'd0, 32'd0);
      seen = 1'b0;
      repeat (40) begin
         @(negedge clock);
         if (fire_out) seen = 1'b1;
      end
      check("no_pulse_after_cancel", {31'd0, seen}, 32'd0);
      bus_write(R_FCTRL, 8'd0, 32'd5);
      rd_chk("cancel_beats_sched", R_FCTRL, 8'd0, 32'd0);

      // Immediate fire, requests ignored while active, then async reset mid-pulse
      bus_write(R_FCTRL, 8'd0, 32'd2);
      check("fire_now", {31'd0, fire_out}, 32'd1);
      rd_chk("fire_active", R_FCTRL, 8'd0, 32'd2);
      bus_write(R_FCTRL, 8'd0, 32'd1);
      rd_chk("sched_ignored", R_FCTRL, 8'd0, 32'd2);
      @(negedge clock);
      #2 reset_n = 1'b0;
      #1;
      check("async_rst_fire", {31'd0, fire_out}, 32'd0);
      check("async_rst_rdata", readdata, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      rd_chk("post_rst_time", R_TIME, 8'd0, 32'd0);
      rd_chk("post_rst_status0", R_STAT, 8'd0, 32'd0);
      rd_chk("post_rst_cap0", R_CAP, 8'd0, 32'd0);
      rd_chk("post_rst_ftime", R_FTIME, 8'd0, 32'd0);
      rd_chk("post_rst_fctrl", R_FCTRL, 8'd0, 32'd0);

      // Bus edge cases
      bus_read(R_CAP, 8'd7, d, w);
      check("bad_ch_data", d, 32'hDEAD_BEEF);
      check("bad_ch_waits", w, 32'd1);
      rd_chk("bad_ch4_status", R_STAT, 8'd4, 32'hDEAD_BEEF);
      rd_chk("bad_reg7", 8'h07, 8'd0, 32'hDEAD_BEEF);
`ifdef RTC_EDGE_SELECT_EN
      rd_chk("edge_sel_rst", R_ESEL, 8'd0, 32'd0);
`else
      rd_chk("edge_sel_absent", R_ESEL, 8'd0, 32'hDEAD_BEEF);
`endif
      bus_write(R_STAT, 8'd7, 32'd1);
      rd_chk("bad_ch_wr_ignored", R_STAT, 8'd3, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/rtc_multi_capture.md
Name: rtc_multi_capture

Overview:
- Parametrised successor to the single-channel real-time clock.
- Free-running prescaled timebase plus NUM_CH independent armed timestamp-capture channels.
- One scheduled or immediate output pulse with a latched fire timestamp (piezo drive).
- Sits behind the lightweight HPS-to-FPGA bridge as an Avalon-MM slave used by the multilateration software.

Parameters:
- NUM_CH, 4: number of event capture channels (1..16).
- CNT_W, 32: timebase width (8..32); readdata is zero-extended.
- PRESCALE, 5: clocks per timebase tick (1 = every clock; 5 = 100 ns at 50 MHz).
- SYNC_STAGES, 2: synchroniser flops on each event input (2..3).
- PULSE_TICKS, 10: fire_out high time, in timebase ticks (>=1).

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- event_in  in  NUM_CH  asynchronous event inputs, one per channel
- avalon_slave_address  in  16  [15:8] register select, [7:0] channel index
- avalon_slave_write  in  1  write strobe
- avalon_slave_writedata  in  32  write data
- avalon_slave_read  in  1  read strobe
- avalon_slave_readdata  out  32  read data
- avalon_slave_waitrequest  out  1  Avalon wait request
- fire_out  out  1  output pulse (piezo enable)
- capture_irq  out  1  OR of all channel valid flags

Behaviour:
- Reset: all registers 0, fire FSM IDLE, fire_out=0, capture_irq=0, readdata=0, waitrequest=0 when no read is active.
- Timebase:
  - Prescaler counts 0..PRESCALE-1; tick asserts on the wrap cycle.
  - time_cnt increments on each tick and wraps from 2^CNT_W-1 to 0.
- Register map (address[15:8]):
  - 0x00 TIME (rw): a write loads time_cnt and clears the prescaler; the write beats a same-cycle tick.
  - 0x01 CAPTURE[ch] (r): captured timestamp.
  - 0x02 STATUS[ch] (rw): read bit0=armed, bit1=valid, bit2=overrun. Write bit0=1 arms and clears valid/overrun; write bit1=1 disarms; if both bits are set, disarm wins.
  - 0x03 FIRE_TIME (rw): compare value.
  - 0x04 FIRE_CTRL (rw): write bit0 schedules, bit1 fires immediately, bit2 cancels; read bit0=pending, bit1=active.
  - 0x05 FIRE_STAMP (r): time_cnt at the fire_out rising edge.
  - Other registers, or channel index >= NUM_CH: read 32'hDEADBEEF, writes ignored.
- Read handshake:
  - Waitrequest is high during the first read cycle.
  - readdata is registered and waitrequest is low on the second cycle, so latency is 1 wait state.
- Writes: zero wait states; waitrequest stays low.
- Capture channel:
  - Path: synchroniser, then rising-edge detect.
  - A detect while armed captures the time_cnt of that cycle, sets valid, clears armed. Input edge to valid is SYNC_STAGES+1 clocks.
  - A detect while unarmed with valid=1 sets overrun; CAPTURE is not overwritten.
  - A detect while unarmed with valid=0 is ignored.
  - A STATUS write in the same cycle as a detect: the write wins and the edge is dropped.
- Fire FSM (IDLE, PENDING, ACTIVE):
  - IDLE to PENDING on schedule.
  - PENDING to ACTIVE on the tick cycle where time_cnt advances to FIRE_TIME. A FIRE_TIME in the past waits for wrap-around.
  - Immediate fire goes to ACTIVE on the next clock from IDLE or PENDING.
  - Entering ACTIVE sets fire_out=1 and latches FIRE_STAMP.
  - ACTIVE lasts PULSE_TICKS ticks, then goes to IDLE with fire_out=0.
  - Cancel: PENDING or ACTIVE go to IDLE next clock.
  - Schedule or fire requests while ACTIVE are ignored.
  - Cancel and schedule in the same write: cancel wins.
- Asynchronous reset mid-pulse: fire_out drops immediately.

Optional Feature:
- Macro: RTC_EDGE_SELECT_EN.
- Defined: adds register 0x06 EDGE_SEL[ch] (rw, bits[1:0]): 00 rising, 01 falling, 10 both, 11 rising. Reset value is 00.
- Undefined: rising-only detection; 0x06 reads DEADBEEF and writes are ignored.

Decomposition:
- Package rtc_pkg:
  - register-index localparams (REG_TIME..REG_EDGE_SEL),
  - STATUS and FIRE_CTRL bit positions,
  - fire FSM state enum,
  - DEADBEEF constant.
- Sub-module rtc_capture_channel, instantiated NUM_CH times: synchroniser, edge detect, armed/valid/overrun, capture register.

Test Plan:
- Timebase: PRESCALE=5, write TIME=0xFFFFFFFE, wait 15 clocks -> TIME reads 0x00000001 (wrap verified).
- Single-channel capture: arm ch2, pulse event_in[2] when time_cnt=0x100 -> CAPTURE[2]=0x100, STATUS[2]=0b010, capture_irq=1, event-to-valid latency 3 clocks.
- Overrun: ch0 valid, second edge -> STATUS[0]=0b110, CAPTURE unchanged; re-arm -> STATUS[0]=0b001, irq=0.
- Scheduled fire: FIRE_TIME=0x200, schedule -> fire_out rises as time_cnt reaches 0x200, high 50 clocks, FIRE_STAMP=0x200, FIRE_CTRL reads 0 afterwards.
- Cancel and reset: schedule, cancel before match -> no pulse; immediate fire then reset_n low mid-pulse -> fire_out 0 asynchronously, all registers 0.
- Bus edge cases: read channel index 7 with NUM_CH=4 -> DEADBEEF after exactly 1 wait state; arm write coincident with edge -> armed=1, valid=0.
